// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_pkg
//  Description : Shared Tuse/Tnew encodings and forward-select codes for the
//                hazard unit and its tracker stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

    localparam logic [3:0] T_USE_AT_D        = 4'd0;
    localparam logic [3:0] T_USE_AT_E        = 4'd1;
    localparam logic [3:0] T_USE_AT_M        = 4'd2;
    localparam logic [3:0] T_USE_NEVER_READ  = 4'hF;

    localparam logic [3:0] T_NEW_NO_NEW      = 4'd0;
    localparam logic [3:0] T_NEW_AT_ID_EX    = 4'd1;
    localparam logic [3:0] T_NEW_AT_EX_MEM   = 4'd2;
    localparam logic [3:0] T_NEW_AT_MEM_WB   = 4'd3;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_E    = 2'd1,
        FWD_M    = 2'd2,
        FWD_W    = 2'd3
    } fwd_sel_e;

endpackage : hazard_unit_pkg
`default_nettype wire

// File: rtl/hazard_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stage_reg
//  Description : One pipeline tracker stage holding {RegWAddr, Tnew, Rs, Rt}
//                with bubble insertion and saturating Tnew countdown.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stage_reg #(
    parameter int TW = 4,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_bubble,
    input  logic [AW-1:0] i_waddr,
    input  logic [TW-1:0] i_tnew,
    input  logic [AW-1:0] i_rs,
    input  logic [AW-1:0] i_rt,
    output logic [AW-1:0] o_waddr,
    output logic [TW-1:0] o_tnew,
    output logic [AW-1:0] o_rs,
    output logic [AW-1:0] o_rt
);

    logic [AW-1:0] r_waddr_q, w_waddr_d;
    logic [TW-1:0] r_tnew_q,  w_tnew_d;
    logic [AW-1:0] r_rs_q,    w_rs_d;
    logic [AW-1:0] r_rt_q,    w_rt_d;

    always_comb begin
        w_waddr_d = i_waddr;
        w_rs_d    = i_rs;
        w_rt_d    = i_rt;
        // Countdown saturates at zero: a ready result stays ready downstream.
        w_tnew_d  = (i_tnew == '0) ? '0 : i_tnew - 1'b1;
        if (i_bubble) begin
            w_waddr_d = '0;
            w_rs_d    = '0;
            w_rt_d    = '0;
            w_tnew_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waddr_q <= '0;
            r_tnew_q  <= '0;
            r_rs_q    <= '0;
            r_rt_q    <= '0;
        end else begin
            r_waddr_q <= w_waddr_d;
            r_tnew_q  <= w_tnew_d;
            r_rs_q    <= w_rs_d;
            r_rt_q    <= w_rt_d;
        end
    end

    assign o_waddr = r_waddr_q;
    assign o_tnew  = r_tnew_q;
    assign o_rs    = r_rs_q;
    assign o_rt    = r_rt_q;

endmodule : hazard_stage_reg
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Tuse/Tnew hazard unit for a 5-stage pipeline: tracks in-flight
//                producers in E/M/W and drives stall and forward selects.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int TW = 4,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] HU_i_RsD,
    input  logic [AW-1:0] HU_i_RtD,
    input  logic [TW-1:0] HU_i_TuseRs,
    input  logic [TW-1:0] HU_i_TuseRt,
    input  logic [TW-1:0] HU_i_TnewD,
    input  logic [AW-1:0] HU_i_RegWAddrD,
    output logic          HU_o_Stall,
    output logic [1:0]    HU_o_FwdRsD,
    output logic [1:0]    HU_o_FwdRtD,
    output logic [1:0]    HU_o_FwdRsE,
    output logic [1:0]    HU_o_FwdRtE,
    output logic [1:0]    HU_o_FwdRtM
);

    logic [AW-1:0] w_e_waddr, w_m_waddr, w_w_waddr;
    logic [TW-1:0] w_e_tnew,  w_m_tnew,  w_w_tnew;
    logic [AW-1:0] w_e_rs,    w_m_rs,    w_w_rs;
    logic [AW-1:0] w_e_rt,    w_m_rt,    w_w_rt;
    logic [AW-1:0] w_d_waddr;
    logic          w_unused;

    // A non-writing instruction must never look like a producer of its RegWAddr.
    assign w_d_waddr = (HU_i_TnewD == '0) ? '0 : HU_i_RegWAddrD;

    hazard_stage_reg #(.TW(TW), .AW(AW)) u_stage_e (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (HU_o_Stall),
        .i_waddr  (w_d_waddr),
        .i_tnew   (HU_i_TnewD),
        .i_rs     (HU_i_RsD),
        .i_rt     (HU_i_RtD),
        .o_waddr  (w_e_waddr),
        .o_tnew   (w_e_tnew),
        .o_rs     (w_e_rs),
        .o_rt     (w_e_rt)
    );

    hazard_stage_reg #(.TW(TW), .AW(AW)) u_stage_m (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_waddr  (w_e_waddr),
        .i_tnew   (w_e_tnew),
        .i_rs     (w_e_rs),
        .i_rt     (w_e_rt),
        .o_waddr  (w_m_waddr),
        .o_tnew   (w_m_tnew),
        .o_rs     (w_m_rs),
        .o_rt     (w_m_rt)
    );

    hazard_stage_reg #(.TW(TW), .AW(AW)) u_stage_w (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (1'b0),
        .i_waddr  (w_m_waddr),
        .i_tnew   (w_m_tnew),
        .i_rs     (w_m_rs),
        .i_rt     (w_m_rt),
        .o_waddr  (w_w_waddr),
        .o_tnew   (w_w_tnew),
        .o_rs     (w_w_rs),
        .o_rt     (w_w_rt)
    );

    assign w_unused = ^{w_m_rs, w_w_rs, w_w_rt};

    function automatic logic hit(input logic [AW-1:0] src, input logic [AW-1:0] addr);
        return (src != '0) && (src == addr);
    endfunction

    // Only the nearest matching stage decides; farther copies are stale.
    function automatic logic need_stall(input logic [AW-1:0] src, input logic [TW-1:0] tuse);
        if (tuse == T_USE_NEVER_READ) return 1'b0;
        if (hit(src, w_e_waddr))      return w_e_tnew > tuse;
        if (hit(src, w_m_waddr))      return w_m_tnew > tuse;
        if (hit(src, w_w_waddr))      return w_w_tnew > tuse;
        return 1'b0;
    endfunction

    function automatic logic [1:0] fwd_d(input logic [AW-1:0] src);
        if (hit(src, w_e_waddr)) return (w_e_tnew == '0) ? FWD_E : FWD_NONE;
        if (hit(src, w_m_waddr)) return (w_m_tnew == '0) ? FWD_M : FWD_NONE;
        return FWD_NONE;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [AW-1:0] src);
        if (hit(src, w_m_waddr)) return (w_m_tnew == '0) ? FWD_M : FWD_NONE;
        if (hit(src, w_w_waddr)) return (w_w_tnew == '0) ? FWD_W : FWD_NONE;
        return FWD_NONE;
    endfunction

    always_comb begin
        HU_o_Stall  = need_stall(HU_i_RsD, HU_i_TuseRs) | need_stall(HU_i_RtD, HU_i_TuseRt);
        HU_o_FwdRsD = fwd_d(HU_i_RsD);
        HU_o_FwdRtD = fwd_d(HU_i_RtD);
        HU_o_FwdRsE = fwd_e(w_e_rs);
        HU_o_FwdRtE = fwd_e(w_e_rt);
        HU_o_FwdRtM = (hit(w_m_rt, w_w_waddr) && (w_w_tnew == '0)) ? FWD_W : FWD_NONE;
    end

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Directed self-checking bench for hazard_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, waddr_d;
    logic [3:0] tuse_rs, tuse_rt, tnew_d;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

    int checks   = 0;
    int failures = 0;

    hazard_unit dut (
        .clk            (clk),
        .reset          (reset),
        .HU_i_RsD       (rs_d),
        .HU_i_RtD       (rt_d),
        .HU_i_TuseRs    (tuse_rs),
        .HU_i_TuseRt    (tuse_rt),
        .HU_i_TnewD     (tnew_d),
        .HU_i_RegWAddrD (waddr_d),
        .HU_o_Stall     (stall),
        .HU_o_FwdRsD    (fwd_rs_d),
        .HU_o_FwdRtD    (fwd_rt_d),
        .HU_o_FwdRsE    (fwd_rs_e),
        .HU_o_FwdRtE    (fwd_rt_e),
        .HU_o_FwdRtM    (fwd_rt_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic s, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] c,
                           input logic [1:0] d, input logic [1:0] e);
        chk({tag, "_stall"}, {3'b0, stall}, {3'b0, s});
        chk({tag, "_rsd"},   {2'b0, fwd_rs_d}, {2'b0, a});
        chk({tag, "_rtd"},   {2'b0, fwd_rt_d}, {2'b0, b});
        chk({tag, "_rse"},   {2'b0, fwd_rs_e}, {2'b0, c});
        chk({tag, "_rte"},   {2'b0, fwd_rt_e}, {2'b0, d});
        chk({tag, "_rtm"},   {2'b0, fwd_rt_m}, {2'b0, e});
    endtask

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] tur,
                       input logic [3:0] tut, input logic [3:0] tn, input logic [4:0] wa);
        rs_d = rs; rt_d = rt; tuse_rs = tur; tuse_rt = tut; tnew_d = tn; waddr_d = wa;
        #1;
    endtask

    task automatic nop();
        drv(5'd0, 5'd0, 4'hF, 4'hF, 4'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        nop();
        #6;
        chk_all("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        reset = 1'b0;

        // 1: addu $3 then beq $3
        drv(5'd1, 5'd2, 4'd1, 4'd1, 4'd2, 5'd3);
        chk("t1_prod_stall", {3'b0, stall}, 4'd0);
        tick();
        drv(5'd3, 5'd0, 4'd0, 4'd0, 4'd0, 5'd0);
        chk("t1_stall", {3'b0, stall}, 4'd1);
        tick();
        drv(5'd3, 5'd0, 4'd0, 4'd0, 4'd0, 5'd0);
        chk_all("t1_fwd", 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0);
        flush();

        // 2: lw $5 then addu $5
        drv(5'd2, 5'd0, 4'd1, 4'hF, 4'd3, 5'd5);
        tick();
        drv(5'd5, 5'd0, 4'hF, 4'hF, 4'd0, 5'd0);
        chk("t2_never", {3'b0, stall}, 4'd0);
        drv(5'd5, 5'd6, 4'd1, 4'd1, 4'd2, 5'd7);
        chk("t2_stall", {3'b0, stall}, 4'd1);
        tick();
        drv(5'd5, 5'd6, 4'd1, 4'd1, 4'd2, 5'd7);
        chk_all("t2_release", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        nop();
        chk_all("t2_fwde", 1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0);
        flush();

        // 3: jal then jr $31
        drv(5'd0, 5'd0, 4'hF, 4'hF, 4'd1, 5'd31);
        tick();
        drv(5'd31, 5'd0, 4'd0, 4'hF, 4'd0, 5'd0);
        chk_all("t3_jr", 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        flush();

        // 4: lw $4 then sw rt=$4
        drv(5'd2, 5'd0, 4'd1, 4'hF, 4'd3, 5'd4);
        tick();
        drv(5'd2, 5'd4, 4'd1, 4'd2, 4'd0, 5'd0);
        chk("t4_nostall_e", {3'b0, stall}, 4'd0);
        tick();
        nop();
        chk_all("t4_sw_in_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        chk_all("t4_sw_in_m", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3);
        flush();

        // 5: addu $0 then beq $0,$0
        drv(5'd1, 5'd2, 4'd1, 4'd1, 4'd2, 5'd0);
        tick();
        drv(5'd0, 5'd0, 4'd0, 4'd0, 4'd0, 5'd0);
        chk_all("t5_beq_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        nop();
        chk_all("t5_beq_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        flush();

        // 6: reset mid-stall
        drv(5'd2, 5'd0, 4'd1, 4'hF, 4'd3, 5'd9);
        tick();
        drv(5'd9, 5'd0, 4'd1, 4'hF, 4'd2, 5'd10);
        chk("t6_pre_stall", {3'b0, stall}, 4'd1);
        reset = 1'b1;
        #1;
        chk_all("t6_async", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        reset = 1'b0;
        #1;
        chk_all("t6_after", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        drv(5'd2, 5'd0, 4'd1, 4'hF, 4'd3, 5'd9);
        tick();
        drv(5'd9, 5'd0, 4'd1, 4'hF, 4'd2, 5'd10);
        chk("t6_new_prod", {3'b0, stall}, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_unit
`default_nettype wire
